// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - shared types and constants for the ALU command sequencer
package sys_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_A,
    ST_GET_B,
    ST_GET_FUN,
    ST_ALU_REQ,
    ST_ALU_WAIT,
    ST_SEND_LO,
    ST_SEND_HI,
    ST_SEND_ERR
  } state_t;

  localparam logic [7:0] OP_CC    = 8'hCC;
  localparam logic [7:0] OP_DD    = 8'hDD;
  localparam logic [7:0] ERR_BYTE = 8'hEE;
  localparam int         WAIT_MAX = 4;

  // Function codes understood by the ALU; 4'hF is unused and never answers.
  localparam logic [3:0] FUN_ADD  = 4'h0;
  localparam logic [3:0] FUN_SUB  = 4'h1;
  localparam logic [3:0] FUN_MUL  = 4'h2;
  localparam logic [3:0] FUN_DIV  = 4'h3;
  localparam logic [3:0] FUN_AND  = 4'h4;
  localparam logic [3:0] FUN_OR   = 4'h5;
  localparam logic [3:0] FUN_NAND = 4'h6;
  localparam logic [3:0] FUN_NOR  = 4'h7;
  localparam logic [3:0] FUN_XOR  = 4'h8;
  localparam logic [3:0] FUN_XNOR = 4'h9;
  localparam logic [3:0] FUN_EQ   = 4'hA;
  localparam logic [3:0] FUN_GT   = 4'hB;
  localparam logic [3:0] FUN_LT   = 4'hC;
  localparam logic [3:0] FUN_SHR  = 4'hD;
  localparam logic [3:0] FUN_SHL  = 4'hE;
  localparam logic [3:0] FUN_NONE = 4'hF;

endpackage

// File: rtl/sys_alu_ctrl.sv
// rtl/sys_alu_ctrl.sv - RX byte parser driving the registered ALU and pushing results to the TX FIFO
module sys_alu_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter logic [7:0] P_OP_CC    = OP_CC,
  parameter logic [7:0] P_OP_DD    = OP_DD,
  parameter logic [7:0] P_ERR_BYTE = ERR_BYTE,
  parameter int         P_WAIT_MAX = WAIT_MAX
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic [7:0]  ALU_A,
  output logic [7:0]  ALU_B,
  output logic [3:0]  ALU_FUN,
  output logic        ALU_EN,
  output logic        ALU_CLK_EN,
  input  logic [15:0] ALU_OUT,
  input  logic        ALU_VALID,
  input  logic        FIFO_FULL,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID
);

  localparam int CNT_W = $clog2(P_WAIT_MAX + 1);

  state_t            r_state;
  logic [7:0]        r_a;
  logic [7:0]        r_b;
  logic [3:0]        r_fun;
  logic [15:0]       r_result;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_alu_en;
  logic              r_alu_clk_en;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;

  assign ALU_A      = r_a;
  assign ALU_B      = r_b;
  assign ALU_FUN    = r_fun;
  assign ALU_EN     = r_alu_en;
  assign ALU_CLK_EN = r_alu_clk_en;
  assign TX_DATA    = r_tx_data;
  assign TX_VALID   = r_tx_valid;

  // A send state advances only after the cycle in which r_tx_valid was high,
  // i.e. after the byte was actually written; FIFO_FULL is resampled every edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_fun        <= '0;
      r_result     <= '0;
      r_cnt        <= '0;
      r_alu_en     <= 1'b0;
      r_alu_clk_en <= 1'b0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
    end else begin
      r_alu_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx_valid <= 1'b0;
          if (RX_VALID) begin
            if (RX_DATA == P_OP_CC) begin
              r_state <= ST_GET_A;
            end else if (RX_DATA == P_OP_DD) begin
              r_state      <= ST_GET_FUN;
              r_alu_clk_en <= 1'b1;
            end
          end
        end
        ST_GET_A: begin
          if (RX_VALID) begin
            r_a     <= RX_DATA;
            r_state <= ST_GET_B;
          end
        end
        ST_GET_B: begin
          if (RX_VALID) begin
            r_b          <= RX_DATA;
            r_state      <= ST_GET_FUN;
            r_alu_clk_en <= 1'b1;
          end
        end
        ST_GET_FUN: begin
          if (RX_VALID) begin
            r_fun    <= RX_DATA[3:0];
            r_state  <= ST_ALU_REQ;
            r_alu_en <= 1'b1;
          end
        end
        ST_ALU_REQ: begin
          r_cnt   <= '0;
          r_state <= ST_ALU_WAIT;
        end
        ST_ALU_WAIT: begin
          if (ALU_VALID) begin
            r_result     <= ALU_OUT;
            r_tx_data    <= ALU_OUT[7:0];
            r_tx_valid   <= ~FIFO_FULL;
            r_alu_clk_en <= 1'b0;
            r_state      <= ST_SEND_LO;
          end else if (r_cnt == CNT_W'(P_WAIT_MAX - 1)) begin
            r_tx_data    <= P_ERR_BYTE;
            r_tx_valid   <= ~FIFO_FULL;
            r_alu_clk_en <= 1'b0;
            r_state      <= ST_SEND_ERR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SEND_LO: begin
          r_tx_valid <= ~FIFO_FULL;
          if (r_tx_valid) begin
            r_tx_data <= r_result[15:8];
            r_state   <= ST_SEND_HI;
          end else begin
            r_tx_data <= r_result[7:0];
          end
        end
        ST_SEND_HI, ST_SEND_ERR: begin
          if (r_tx_valid) begin
            r_tx_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_tx_valid <= ~FIFO_FULL;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_alu_clk_en <= 1'b0;
          r_tx_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule
